// File: rtl/adc_scheduler_if.sv
// Result-FIFO read port of adc_scheduler: head data, valid/ready handshake and fill level.
interface adc_scheduler_if;
  logic [17:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [4:0]  FIFO_LEVEL;

  modport master (output OUT_DATA, output OUT_VALID, output FIFO_LEVEL, input OUT_READY);
  modport slave  (input OUT_DATA, input OUT_VALID, input FIFO_LEVEL, output OUT_READY);
endinterface

// File: rtl/adc_scheduler.sv
// Schedules periodic and one-shot (A/B) conversions on a dual 8-bit ADC into a result FIFO.
// Optional converter watchdog: define ADC_SCHED_TIMEOUT_EN (otherwise TIMEOUT is tied 0).
module adc_scheduler #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic            CLOCK_50MHz,
  input  logic            RESET_n,
  input  logic [15:0]     PERIOD,
  input  logic            REQ_A,
  input  logic            REQ_B,
  output logic            ACK_A,
  output logic            ACK_B,
  output logic            ADC_START,
  input  logic            ADC_BUSY,
  input  logic [7:0]      ADC_D0,
  input  logic [7:0]      ADC_D1,
  adc_scheduler_if.master out_if,
  output logic            OVERFLOW,
  output logic            TICK_MISS,
  output logic            TIMEOUT
);

  localparam int DATA_W = 8;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [1:0] SRC_T = 2'b00;
  localparam logic [1:0] SRC_A = 2'b01;
  localparam logic [1:0] SRC_B = 2'b10;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1)
  begin : g_bad_param
    $error("adc_scheduler: FIFO_DEPTH must be a power of two in 2..16 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {IDLE, ARM, CONV, STORE} state_t;

  state_t                    state;
  logic                      busy_m, busy_s;
  logic                      req_a_q, req_b_q;
  logic                      rise_a, rise_b;
  logic [15:0]               tmr;
  logic                      tick;
  logic                      pend_t, pend_a, pend_b;
  logic                      rr_b;
  logic                      gnt_t, gnt_a, gnt_b;
  logic [1:0]                tag;
  logic [2*DATA_W+1:0]       cap_p0;
  logic [2*DATA_W+1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [4:0]                level;
  logic                      full, pop, can_push, push;

  // ADC_BUSY comes from the converter's clock domain
  always_ff @(posedge CLOCK_50MHz) begin
    if (!RESET_n) begin
      busy_m <= 1'b0;
      busy_s <= 1'b0;
    end else begin
      busy_m <= ADC_BUSY;
      busy_s <= busy_m;
    end
  end

  always_ff @(posedge CLOCK_50MHz) begin
    if (!RESET_n) begin
      req_a_q <= 1'b0;
      req_b_q <= 1'b0;
    end else begin
      req_a_q <= REQ_A;
      req_b_q <= REQ_B;
    end
  end

  assign rise_a = REQ_A & ~req_a_q;
  assign rise_b = REQ_B & ~req_b_q;

  // A shrunk PERIOD can leave tmr past the new limit: restart silently
  assign tick = (PERIOD != 16'd0) && (tmr == PERIOD - 16'd1);

  always_ff @(posedge CLOCK_50MHz) begin
    if (!RESET_n)
      tmr <= 16'd0;
    else if (PERIOD == 16'd0 || tmr >= PERIOD || tick)
      tmr <= 16'd0;
    else
      tmr <= tmr + 16'd1;
  end

  assign gnt_t = (state == IDLE) & pend_t;
  assign gnt_a = (state == IDLE) & ~pend_t & pend_a & (~pend_b | ~rr_b);
  assign gnt_b = (state == IDLE) & ~pend_t & pend_b & (~pend_a | rr_b);

  always_ff @(posedge CLOCK_50MHz) begin
    if (!RESET_n) begin
      pend_t    <= 1'b0;
      pend_a    <= 1'b0;
      pend_b    <= 1'b0;
      TICK_MISS <= 1'b0;
    end else begin
      pend_t <= (pend_t & ~gnt_t) | tick;
      pend_a <= (pend_a & ~gnt_a) | rise_a;
      pend_b <= (pend_b & ~gnt_b) | rise_b;
      if (tick && pend_t && !gnt_t)
        TICK_MISS <= 1'b1;
    end
  end

`ifdef ADC_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] tmo;
  logic          tmo_hit;

  assign tmo_hit = (tmo == TW'(TIMEOUT_CYC - 1));

  // Restarts on every state change, so it measures the wait for one busy_s edge
  always_ff @(posedge CLOCK_50MHz) begin
    if (!RESET_n)
      tmo <= '0;
    else if ((state == ARM && !busy_s && !tmo_hit) || (state == CONV && busy_s && !tmo_hit))
      tmo <= tmo + TW'(1);
    else
      tmo <= '0;
  end
`else
  assign TIMEOUT = 1'b0;
`endif

  always_ff @(posedge CLOCK_50MHz) begin
    if (!RESET_n) begin
      state     <= IDLE;
      ADC_START <= 1'b0;
      ACK_A     <= 1'b0;
      ACK_B     <= 1'b0;
      tag       <= SRC_T;
      rr_b      <= 1'b0;
      OVERFLOW  <= 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
      TIMEOUT   <= 1'b0;
`endif
    end else begin
      ACK_A <= 1'b0;
      ACK_B <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_t || gnt_a || gnt_b) begin
            tag       <= gnt_a ? SRC_A : (gnt_b ? SRC_B : SRC_T);
            if (gnt_a) rr_b <= 1'b1;
            if (gnt_b) rr_b <= 1'b0;
            ADC_START <= 1'b1;
            state     <= ARM;
          end
        end
        ARM: begin
          if (busy_s) begin
            ADC_START <= 1'b0;
            state     <= CONV;
          end
`ifdef ADC_SCHED_TIMEOUT_EN
          else if (tmo_hit) begin
            ADC_START <= 1'b0;
            TIMEOUT   <= 1'b1;
            ACK_A     <= (tag == SRC_A);
            ACK_B     <= (tag == SRC_B);
            state     <= IDLE;
          end
`endif
        end
        CONV: begin
          // ACK is raised here so it is high during the STORE cycle
          if (!busy_s) begin
            ACK_A <= (tag == SRC_A);
            ACK_B <= (tag == SRC_B);
            state <= STORE;
          end
`ifdef ADC_SCHED_TIMEOUT_EN
          else if (tmo_hit) begin
            TIMEOUT <= 1'b1;
            ACK_A   <= (tag == SRC_A);
            ACK_B   <= (tag == SRC_B);
            state   <= IDLE;
          end
`endif
        end
        STORE: begin
          if (!can_push)
            OVERFLOW <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture stage: converter result tagged with its source
  always_ff @(posedge CLOCK_50MHz) begin
    if (state == CONV && !busy_s)
      cap_p0 <= {tag, ADC_D1, ADC_D0};
  end

  // Store stage: first-word fall-through FIFO
  assign full     = (level == 5'(FIFO_DEPTH));
  assign pop      = out_if.OUT_READY & (level != 5'd0);
  assign can_push = ~full | pop;
  assign push     = (state == STORE) & can_push;

  always_ff @(posedge CLOCK_50MHz) begin
    if (push)
      mem[wr_ptr] <= cap_p0;
  end

  always_ff @(posedge CLOCK_50MHz) begin
    if (!RESET_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + {4'd0, push} - {4'd0, pop};
    end
  end

  assign out_if.OUT_VALID  = (level != 5'd0);
  assign out_if.OUT_DATA   = out_if.OUT_VALID ? mem[rd_ptr] : '0;
  assign out_if.FIFO_LEVEL = level;

endmodule

// File: doc/adc_scheduler.md
ADC_SCHEDULER -- requirements
Module: adc_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, result FIFO entries (power of two, 2..16).
REQ-002 Parameter TIMEOUT_CYC, default 1024, watchdog limit in CLOCK_50MHz cycles.
REQ-003 CLOCK_50MHz  in  1  system clock; all logic rising-edge.
REQ-004 RESET_n  in  1  synchronous, active-low reset.
REQ-005 PERIOD  in  16  periodic sample interval in cycles; 0 = periodic source off.
REQ-006 REQ_A, REQ_B  in  1 each  one-shot sample requests, rising-edge detected.
REQ-007 ACK_A, ACK_B  out  1 each  one-cycle pulse when that requester's sample is stored or dropped.
REQ-008 ADC_START  out  1  conversion request to the dual 8-bit converter.
REQ-009 ADC_BUSY  in  1  converter busy, asynchronous to CLOCK_50MHz.
REQ-010 ADC_D0, ADC_D1  in  8 each  converter results, valid when ADC_BUSY low.
REQ-011 OUT_DATA  out  18  {src[1:0], D1[7:0], D0[7:0]}; src 00 timer, 01 A, 10 B.
REQ-012 OUT_VALID  out  1 / OUT_READY  in  1  FIFO read handshake; pop when both high.
REQ-013 FIFO_LEVEL  out  5  entries held.
REQ-014 OVERFLOW, TICK_MISS, TIMEOUT  out  1 each  sticky error flags.

Function
REQ-015 ADC_BUSY passes a 2-flop synchronizer (busy_s) before any use.
REQ-016 Timer: counter 0..PERIOD-1, tick at PERIOD-1 then 0; held 0 when PERIOD=0; if counter>=PERIOD after a PERIOD change, reload 0 without tick.
REQ-017 Tick sets pend_T; tick while pend_T already set keeps one pend_T and sets TICK_MISS.
REQ-018 REQ_A/REQ_B rising edge sets pend_A/pend_B; edges while pending are merged.
REQ-019 FSM states IDLE, ARM, CONV, STORE.
REQ-020 IDLE: grant pend_T first, else A/B round-robin (A favoured after reset, pointer flips after each A/B grant); clear granted pend; go ARM next cycle.
REQ-021 ARM: ADC_START=1 until busy_s=1, then CONV; ADC_START=0 in all other states.
REQ-022 CONV: on busy_s=0 capture ADC_D0/ADC_D1 with grant tag, go STORE.
REQ-023 STORE (1 cycle): push if not full, or if full with simultaneous pop (level unchanged); else drop and set OVERFLOW; pulse ACK_A/ACK_B for A/B grants; return IDLE.
REQ-024 Sample-to-FIFO latency after busy_s falls: 2 cycles (capture, store); OUT_VALID high the cycle after push.
REQ-025 FIFO: first-word fall-through, OUT_DATA = head entry; pop on empty ignored; FIFO_LEVEL saturates at FIFO_DEPTH.
REQ-026 Requests and ticks arriving in ARM/CONV/STORE are pended, never lost except per REQ-017.

Reset
REQ-027 RESET_n low: FSM IDLE, ADC_START=0, ACK_A=ACK_B=0, OUT_VALID=0, OUT_DATA=0, FIFO_LEVEL=0, all sticky flags 0, pend_* 0, timer 0, RR pointer A, synchronizer 0.
REQ-028 Reset mid-conversion abandons the sample with no ACK; flags clear only by reset.

Configuration
REQ-029 ADC_SCHED_TIMEOUT_EN defined: counter in ARM and CONV; TIMEOUT_CYC cycles without the awaited busy_s edge sets TIMEOUT, drops ADC_START, returns IDLE, no push, ACK still pulsed for A/B.
REQ-030 ADC_SCHED_TIMEOUT_EN undefined: ARM/CONV wait indefinitely; TIMEOUT tied 0.

Verification
REQ-031 PERIOD=100, converter model busy 40 cycles, OUT_READY=1 -> one src=00 entry every 100 cycles, data matches model, no flags.
REQ-032 REQ_A and REQ_B same cycle, PERIOD=0 -> A serviced then B, ACK_A before ACK_B, tags 01 then 10.
REQ-033 Tick and REQ_A same cycle while IDLE -> timer sample first, A second.
REQ-034 OUT_READY=0, FIFO_DEPTH+1 samples -> FIFO_LEVEL=4, OVERFLOW=1, fifth sample dropped; full push with simultaneous pop keeps level 4, no overflow.
REQ-035 PERIOD=10, busy 40 cycles -> TICK_MISS=1, no extra conversions queued.
REQ-036 With ADC_SCHED_TIMEOUT_EN, ADC_BUSY held low -> TIMEOUT=1 after 1024 ARM cycles, FSM IDLE, FIFO_LEVEL unchanged.
